sram_nblk_loader: RTL
=====================

Name: sram_nblk_loader

Overview:
- Parametrised successor to the fixed 8-block, 256x20 coefficient SRAM used by the FIR datapath.
- Provides NBLK independent SRAM blocks of DEPTH words by WIDTH bits.
- A streaming valid/ready loader fills all blocks in block-major order from one write stream. It replaces external linear-address writes.
- All NBLK blocks are read in parallel through per-block addresses, with an optional output register and write-first bypass.

Parameters:
NBLK, 8, number of SRAM blocks (>=1)
DEPTH, 256, words per block (power of 2, >=2)
WIDTH, 20, data bits per word
OREG, 0, 0 = read latency 1 cycle, 1 = extra output register, latency 2
(derived) AW = clog2(DEPTH); TOTAL = NBLK*DEPTH; CW = clog2(TOTAL)+1

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin or restart a load at linear address 0
ld_valid  in  1  loader word valid
ld_ready  out  1  loader can accept a word
ld_data  in  WIDTH  loader write data
busy  out  1  load in progress
done  out  1  all TOTAL words written (sticky)
ld_count  out  CW  words accepted since last start
rd_en  in  1  sample rd_addr and launch a read on all blocks
rd_addr  in  NBLK*AW  packed per-block read addresses, block k at [k*AW +: AW]
rd_valid  out  1  q carries data for a launched read
q  out  NBLK*WIDTH  packed read data, block k at [k*WIDTH +: WIDTH]

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - ld_ready, busy, done, rd_valid, ld_count, q and the OREG stage are all 0.
  - Memory contents are not reset.
  - No write occurs while rst_n is low.
- FSM states and transitions:
  - IDLE --start--> LOAD.
  - LOAD --last handshake--> DONE.
  - DONE --start--> LOAD.
  - start in LOAD restarts the load; start has priority over a same-cycle handshake, and that word is discarded.
  - Entering LOAD: ptr=0, ld_count=0, done=0.
- Loader signals:
  - ld_ready = (state==LOAD), a registered state decode with no combinational path from ld_valid.
  - busy = (state==LOAD).
  - Handshake = ld_valid & ld_ready. On a handshake, ld_data is written to block ptr/DEPTH at address ptr%DEPTH, then ptr and ld_count increment.
  - The handshake at ptr==TOTAL-1 moves to DONE. done=1 and ld_count=TOTAL on the next edge.
  - The pointer never wraps. Words offered in IDLE or DONE are not accepted and memory is unchanged.
- Read path:
  - On rd_en, each block k reads rd_addr slice k.
  - OREG=0: q and rd_valid update on the next edge.
  - OREG=1: one further register stage is added; rd_valid is pipelined identically.
  - Without rd_en, rd_valid=0 and q holds its last value.
- Collision: a write to block k at address a in the same cycle as a read of block k at address a returns the new ld_data (write-first). Other blocks are unaffected.
- Reads and loading may overlap freely. rd_en is honoured in every state.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately ld_ready=0, busy=0, done=0, ld_count=0, rd_valid=0, q=0. Release, no start -> ld_ready stays 0.
- Full load with defaults:
  - Stimulus: start, then ld_data=index 0..2047 with ld_valid dropped every 3rd cycle.
  - Required: exactly 2048 handshakes; done=1 and ld_count=2048 one cycle after the last handshake; busy=0.
  - Then rd_en with all rd_addr=5 -> next cycle rd_valid=1 and q block k = k*256+5.
- Overrun after done: hold ld_valid=1 with ld_data=0xFFFFF for 10 cycles -> ld_ready=0 and a reread of addr 5 is unchanged.
- Bypass: start, write word 0=0x12345 in the same cycle as rd_en with block0 addr 0 -> q block0=0x12345 next cycle.
- Restart mid-load: after 100 handshakes, pulse start together with ld_valid -> that word is discarded and ld_count=0. The next word lands at block0 addr0; done stays 0.
- OREG=1 build: rd_en for one cycle -> rd_valid and q appear exactly 2 cycles later. Assert rst_n low during a load -> no write that cycle, and reloading from start completes normally.

Source files
------------

// File: rtl/sram_nblk_loader.sv
// NBLK parallel-read SRAM blocks filled by one block-major valid/ready stream.
// Reads launch on rd_en with write-first bypass; OREG adds one output stage.

module sram_nblk_blk #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 20,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   // Same-cycle write to the address being read returns the incoming word.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  q <= '0;
      else if (re) q <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

module sram_nblk_loader #(
   parameter int NBLK  = 8,
   parameter int DEPTH = 256,
   parameter int WIDTH = 20,
   parameter int OREG  = 0,
   localparam int AW    = $clog2(DEPTH),
   localparam int TOTAL = NBLK * DEPTH,
   localparam int CW    = $clog2(TOTAL) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [WIDTH-1:0]      ld_data,
   output logic                  busy,
   output logic                  done,
   output logic [CW-1:0]         ld_count,
   input  logic                  rd_en,
   input  logic [NBLK*AW-1:0]    rd_addr,
   output logic                  rd_valid,
   output logic [NBLK*WIDTH-1:0] q
);
   localparam int STAGES = (OREG != 0) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t state;

   logic                  we;
   logic [CW-1:0]         wblk;
   logic [NBLK*WIDTH-1:0] q_raw;
   logic [STAGES:1]       vld_r;
   logic [STAGES:0]       vld_pipe;

   // start wins over a same-cycle handshake, so that word never lands.
   assign we   = ld_valid & ld_ready & ~start;
   assign wblk = ld_count >> AW;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         ld_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ld_count <= '0;
      end else if (start) begin
         state    <= LOAD;
         ld_ready <= 1'b1;
         busy     <= 1'b1;
         done     <= 1'b0;
         ld_count <= '0;
      end else if (state == LOAD && ld_valid) begin
         ld_count <= ld_count + 1'b1;
         if (ld_count == CW'(TOTAL - 1)) begin
            state    <= DONE;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
         end
      end

   genvar k;
   generate
      for (k = 0; k < NBLK; k++) begin : g_blk
         sram_nblk_blk #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_blk (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we && wblk == CW'(k)),
            .waddr (ld_count[AW-1:0]),
            .wdata (ld_data),
            .re    (rd_en),
            .raddr (rd_addr[k*AW +: AW]),
            .q     (q_raw[k*WIDTH +: WIDTH])
         );
      end
   endgenerate

   assign vld_pipe = {vld_r, rd_en};
   assign rd_valid = vld_pipe[STAGES];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) vld_r <= '0;
      else        vld_r <= vld_pipe[STAGES-1:0];

   generate
      if (OREG != 0) begin : g_oreg
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)           q <= '0;
            else if (vld_pipe[1]) q <= q_raw;
      end else begin : g_noreg
         assign q = q_raw;
      end
   endgenerate
endmodule
